// File: rtl/gf_serial_mult_if.sv
// Start/operand/result bundle for the bit-serial GF(2^M) multiplier.
// The master issues multiplies and the slave (the multiplier) returns products.
interface gf_serial_mult_if #(
    parameter int M = 13
);
    logic         start;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         busy;
    logic         done;
    logic [M-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/gf_serial_mult.sv
// Bit-serial GF(2^13) polynomial-basis multiplier: one multiplicand bit per
// cycle, accumulating a_i * alpha^i * b over 13 clock cycles.
module gf_serial_mult #(
    parameter int           M    = 13,
    parameter logic [M-1:0] POLY = 13'h001B
) (
    input  logic             clk,
    input  logic             rst,
    gf_serial_mult_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST = 4'(M - 1);

    state_t       state;
    logic         busy;
    logic         done;
    logic [M-1:0] product;
    logic [M-1:0] acc;
    logic [M-1:0] t;
    logic [M-1:0] a_reg;
    logic [3:0]   cnt;
    logic [M-1:0] acc_next;

    // Multiply by alpha, folding the x^M term back through POLY.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    always_comb begin
        acc_next = acc ^ (a_reg[cnt] ? t : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            t       <= '0;
            a_reg   <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_reg <= bus.a;
                        t     <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    t   <= xtime(t);
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= acc_next;
                        cnt     <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule
